// File: rtl/router_pkg.sv
// router_sync shared constants.
// Address encoding and watchdog sizing helpers.
package router_pkg;

    localparam int ADDR_W = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
    localparam int NUM_PORTS = 3;
    localparam int TIMEOUT_DEF = 30;

    function automatic int TO_W(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/router_sync_if.sv
// FSM/FIFO-side signal bundle of the 1x3 router synchroniser.
// master = FSM and FIFOs, slave = router_sync.
interface router_sync_if;
    import router_pkg::*;

    logic              detect_add;
    logic [ADDR_W-1:0] data_in;
    logic              write_enb_reg;
    logic              read_enb_0;
    logic              read_enb_1;
    logic              read_enb_2;
    logic              empty_0;
    logic              empty_1;
    logic              empty_2;
    logic              full_0;
    logic              full_1;
    logic              full_2;
    logic [2:0]        write_enb;
    logic              fifo_full;
    logic              vld_out_0;
    logic              vld_out_1;
    logic              vld_out_2;
    logic              soft_reset_0;
    logic              soft_reset_1;
    logic              soft_reset_2;

    modport master (
        output detect_add, data_in, write_enb_reg,
        output read_enb_0, read_enb_1, read_enb_2,
        output empty_0, empty_1, empty_2,
        output full_0, full_1, full_2,
        input  write_enb, fifo_full,
        input  vld_out_0, vld_out_1, vld_out_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2
    );

    modport slave (
        input  detect_add, data_in, write_enb_reg,
        input  read_enb_0, read_enb_1, read_enb_2,
        input  empty_0, empty_1, empty_2,
        input  full_0, full_1, full_2,
        output write_enb, fifo_full,
        output vld_out_0, vld_out_1, vld_out_2,
        output soft_reset_0, soft_reset_1, soft_reset_2
    );

endinterface

// File: rtl/router_timeout.sv
// Per-port watchdog: flushes a FIFO whose data sits unread
// for TIMEOUT consecutive cycles, with a one-cycle pulse.
module router_timeout
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    localparam int W = TO_W(TIMEOUT);
    localparam logic [W-1:0] LIM = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         pulse_q, pulse_d;

    // The pulse cycle itself never counts, so pulses are one cycle wide.
    always_comb begin
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (!pulse_q && vld && !rd) begin
            if (cnt_q == LIM) pulse_d = 1'b1;
            else              cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign soft_reset = pulse_q;

endmodule

// File: rtl/router_sync.sv
// 1x3 router synchroniser: latches destination, steers writes,
// muxes full flags and runs one timeout watchdog per port.
module router_sync
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clock,
    input  logic         resetn,
    router_sync_if.slave bus
);

    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (bus.detect_add) addr_d = bus.data_in;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) addr_q <= '0;
        else         addr_q <= addr_d;
    end

    // Writes use the registered address, so a same-cycle header
    // write still lands in the previously selected FIFO.
    always_comb begin
        bus.write_enb = 3'b000;
        bus.fifo_full = 1'b0;
        case (addr_q)
            2'd0: begin
                bus.write_enb = {2'b00, bus.write_enb_reg};
                bus.fifo_full = bus.full_0;
            end
            2'd1: begin
                bus.write_enb = {1'b0, bus.write_enb_reg, 1'b0};
                bus.fifo_full = bus.full_1;
            end
            2'd2: begin
                bus.write_enb = {bus.write_enb_reg, 2'b00};
                bus.fifo_full = bus.full_2;
            end
            default: ;
        endcase
    end

    assign bus.vld_out_0 = !bus.empty_0;
    assign bus.vld_out_1 = !bus.empty_1;
    assign bus.vld_out_2 = !bus.empty_2;

    router_timeout #(.TIMEOUT(TIMEOUT)) u_to0 (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (bus.vld_out_0),
        .rd         (bus.read_enb_0),
        .soft_reset (bus.soft_reset_0)
    );

    router_timeout #(.TIMEOUT(TIMEOUT)) u_to1 (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (bus.vld_out_1),
        .rd         (bus.read_enb_1),
        .soft_reset (bus.soft_reset_1)
    );

    router_timeout #(.TIMEOUT(TIMEOUT)) u_to2 (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (bus.vld_out_2),
        .rd         (bus.read_enb_2),
        .soft_reset (bus.soft_reset_2)
    );

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync with TIMEOUT = 30.
// Expected values are hand-derived constants.
module tb_router_sync;

    logic clock;
    logic resetn;
    int   n_chk;
    int   n_err;
    int   n;

    router_sync_if bus ();

    router_sync #(.TIMEOUT(30)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic sr(input int p);
        case (p)
            0:       return bus.soft_reset_0;
            1:       return bus.soft_reset_1;
            default: return bus.soft_reset_2;
        endcase
    endfunction

    // Edges until the port's pulse is seen; 0 if it never comes.
    task automatic wait_pulse(input int p, input int max, output int cnt);
        cnt = 0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (sr(p)) begin
                cnt = i;
                break;
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        resetn = 1'b0;
        bus.detect_add = 1'b0;
        bus.data_in = 2'b00;
        bus.write_enb_reg = 1'b0;
        bus.read_enb_0 = 1'b0;
        bus.read_enb_1 = 1'b0;
        bus.read_enb_2 = 1'b0;
        bus.empty_0 = 1'b1;
        bus.empty_1 = 1'b1;
        bus.empty_2 = 1'b1;
        bus.full_0 = 1'b0;
        bus.full_1 = 1'b0;
        bus.full_2 = 1'b0;
        #3;
        chk("rst_sr", {bus.soft_reset_2, bus.soft_reset_1,
                       bus.soft_reset_0}, 3'b000);
        chk("rst_we", bus.write_enb, 3'b000);
        #9;
        resetn = 1'b1;
        tick();
        bus.write_enb_reg = 1'b1;
        #1 chk("rst_addr0_we", bus.write_enb, 3'b001);
        bus.write_enb_reg = 1'b0;

        bus.empty_1 = 1'b0;
        #1 chk("vld1", bus.vld_out_1, 1'b1);
        chk("vld0", bus.vld_out_0, 1'b0);
        repeat (10) tick();
        chk("cnt1_10", dut.u_to1.cnt_q, 10);
        resetn = 1'b0;
        #1 chk("cnt1_rst", dut.u_to1.cnt_q, 0);
        chk("sr1_rst", bus.soft_reset_1, 1'b0);
        #1 resetn = 1'b1;
        wait_pulse(1, 40, n);
        chk("post_rst_full_cnt", n, 30);
        bus.empty_1 = 1'b1;
        tick();

        bus.detect_add = 1'b1;
        bus.data_in = 2'b10;
        tick();
        bus.detect_add = 1'b0;
        bus.write_enb_reg = 1'b1;
        #1 chk("steer2", bus.write_enb, 3'b100);
        chk("full2_lo", bus.fifo_full, 1'b0);
        bus.full_0 = 1'b1;
        #1 chk("full0_ignored", bus.fifo_full, 1'b0);
        bus.full_2 = 1'b1;
        #1 chk("full2_hi", bus.fifo_full, 1'b1);
        bus.full_0 = 1'b0;
        bus.full_2 = 1'b0;
        bus.write_enb_reg = 1'b0;

        bus.detect_add = 1'b1;
        bus.data_in = 2'b01;
        tick();
        bus.detect_add = 1'b0;
        bus.write_enb_reg = 1'b1;
        bus.full_1 = 1'b1;
        #1 chk("steer1", bus.write_enb, 3'b010);
        chk("full1_hi", bus.fifo_full, 1'b1);
        bus.full_1 = 1'b0;
        bus.write_enb_reg = 1'b0;

        bus.detect_add = 1'b1;
        bus.data_in = 2'b11;
        tick();
        bus.detect_add = 1'b0;
        bus.write_enb_reg = 1'b1;
        bus.full_0 = 1'b1;
        bus.full_1 = 1'b1;
        bus.full_2 = 1'b1;
        #1 chk("steer_inv", bus.write_enb, 3'b000);
        chk("full_inv", bus.fifo_full, 1'b0);
        bus.full_0 = 1'b0;
        bus.full_1 = 1'b0;
        bus.full_2 = 1'b0;
        bus.write_enb_reg = 1'b0;

        bus.detect_add = 1'b1;
        bus.data_in = 2'b00;
        tick();
        bus.data_in = 2'b01;
        bus.write_enb_reg = 1'b1;
        #1 chk("same_cyc_old", bus.write_enb, 3'b001);
        tick();
        bus.detect_add = 1'b0;
        #1 chk("same_cyc_new", bus.write_enb, 3'b010);
        bus.write_enb_reg = 1'b0;

        bus.empty_0 = 1'b0;
        wait_pulse(0, 40, n);
        chk("to0_latency", n, 30);
        chk("to0_no_sr1", bus.soft_reset_1, 1'b0);
        chk("to0_no_sr2", bus.soft_reset_2, 1'b0);
        tick();
        chk("to0_width", bus.soft_reset_0, 1'b0);
        bus.empty_0 = 1'b1;
        tick();

        bus.empty_0 = 1'b0;
        wait_pulse(0, 40, n);
        chk("to0_again", n, 30);
        resetn = 1'b0;
        #1 chk("inflight_rst", bus.soft_reset_0, 1'b0);
        bus.empty_0 = 1'b1;
        #1 resetn = 1'b1;
        tick();

        bus.empty_1 = 1'b0;
        repeat (29) tick();
        chk("near_pre", bus.soft_reset_1, 1'b0);
        bus.read_enb_1 = 1'b1;
        tick();
        chk("near_read", bus.soft_reset_1, 1'b0);
        bus.read_enb_1 = 1'b0;
        wait_pulse(1, 40, n);
        chk("near_restart", n, 30);
        bus.empty_1 = 1'b1;
        tick();

        bus.empty_2 = 1'b0;
        wait_pulse(2, 40, n);
        chk("pers_first", n, 30);
        wait_pulse(2, 40, n);
        chk("pers_second", n, 31);
        bus.empty_2 = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/router_sync.md
# router_sync

Synchroniser between the router input FSM and the three output FIFOs of the 1x3 router. Latches the 2-bit destination address from the header byte and steers the FSM's write strobe to exactly one FIFO. Reflects the selected FIFO's full flag back to the FSM and drives a valid flag per output port. Runs one timeout watchdog per port that issues `soft_reset` to a FIFO whose data is not read within `TIMEOUT` cycles.

## Interface
Parameters:
- `TIMEOUT`, default 30: number of consecutive unread valid cycles before a port's soft reset fires; legal range 2..63.

Ports:
- `clock` input 1: single clock, all state on its rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `detect_add` input 1: header on `data_in` this cycle; latch address.
- `data_in` input 2: destination address, header bits [1:0].
- `write_enb_reg` input 1: write strobe from the FSM.
- `read_enb_0`, `read_enb_1`, `read_enb_2` input 1 each: per-port read strobes from downstream.
- `empty_0`, `empty_1`, `empty_2` input 1 each: per-FIFO empty flags.
- `full_0`, `full_1`, `full_2` input 1 each: per-FIFO full flags.
- `write_enb` output 3: one-hot FIFO write enables; bit n feeds FIFO n.
- `fifo_full` output 1: full flag of the currently addressed FIFO.
- `vld_out_0`, `vld_out_1`, `vld_out_2` output 1 each: port has data.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` output 1 each: one-cycle timeout flush pulses, one per FIFO.

## Operation
- **Address register (2 bits):**
  - Loads `data_in` on each edge where `detect_add`=1; otherwise holds.
  - Reset value 2'b00.
- **Write steering (combinational from the registered address):**
  - Address 0/1/2 drives `write_enb` = `{2'b00,write_enb_reg}`, `{1'b0,write_enb_reg,1'b0}` and `{write_enb_reg,2'b00}` respectively.
  - Address 2'b11 is invalid: `write_enb`=3'b000 and `fifo_full`=0.
- **Full mux:** `fifo_full` = `full_n` of the registered address (combinational).
- **Valid:** `vld_out_n` = `!empty_n` (combinational).
- **Timeout watchdog, per port n:**
  - Counter `cnt_n`, width `TO_W`, reset value 0.
  - A qualifying edge is one where `vld_out_n`=1 and `read_enb_n`=0.
  - On a qualifying edge with `cnt_n` < `TIMEOUT-1`: `cnt_n` increments and `soft_reset_n` is 0.
  - On a qualifying edge with `cnt_n` == `TIMEOUT-1`: `cnt_n` becomes 0 and `soft_reset_n` becomes 1.
  - On any non-qualifying edge: `cnt_n` becomes 0 and `soft_reset_n` becomes 0.
  - On the edge after `soft_reset_n`=1, `soft_reset_n` returns to 0 regardless of inputs, so the pulse is exactly one cycle. `cnt_n` is held at 0 on that edge.
  - The three watchdogs are fully independent.

## Timing
- **Reset:** with `resetn` low, all outputs are driven immediately, not waiting for a clock edge:
  - address = 2'b00, all `cnt_n`=0, all `soft_reset_n`=0;
  - `write_enb`, `fifo_full` and `vld_out_n` follow their inputs combinationally.
- **Combinational paths:** `write_enb`, `fifo_full` and `vld_out_n` have zero latency from their inputs.
- **Address latch:** a new address steers writes from the cycle after the `detect_add` edge.
  - If `detect_add` and `write_enb_reg` are both high in the same cycle, the write uses the old address.
- **Timeout latency:** with `vld_out_n` stuck high and no reads, `soft_reset_n` rises after the `TIMEOUT`-th qualifying edge and falls one edge later.
- **Read before expiry:** a read on qualifying edge k (k ≤ `TIMEOUT`) means no pulse fires, and counting restarts from 0.
- **Repeated pulses:** if the flushed FIFO still reports non-empty after the pulse, counting restarts. The next pulse comes `TIMEOUT` edges after the first pulse falls.
- **Reset mid-count:** asserting `resetn` low clears the counters and any in-flight pulse at once.

## Structure
- Package `router_pkg` holds:
  - `ADDR_W`=2;
  - `ADDR_INVALID`=2'b11;
  - `NUM_PORTS`=3;
  - the default `TIMEOUT`;
  - the function `TO_W` = `$clog2(TIMEOUT)`.
- Sub-module `router_timeout`, instantiated three times:
  - ports: `clock`, `resetn`, `vld`, `rd`, `soft_reset`;
  - contains one counter and its pulse register.
- The top level contains the address register, the decode logic and the muxes.

## Test plan
- **Reset:** `resetn`=0 mid-cycle with `cnt_1`=10 → all `soft_reset_n`=0 and counters 0 immediately. After release, `write_enb_reg`=1 alone gives `write_enb`=3'b001.
- **Steering:** `detect_add`=1, `data_in`=2'b10, then `write_enb_reg`=1 → `write_enb`=3'b100.
  - With `full_2`=1 → `fifo_full`=1.
  - With `data_in`=2'b11 latched → `write_enb`=3'b000 and `fifo_full`=0 even when all fulls are 1.
- **Same-cycle latch and write:** address 0 latched; `detect_add`=1 with `data_in`=2'b01 and `write_enb_reg`=1 together → `write_enb`=3'b001 that cycle, then 3'b010 the next cycle.
- **Timeout, `TIMEOUT`=30:** `empty_0`=0 and `read_enb_0`=0 held → `soft_reset_0` high for exactly one cycle after the 30th edge. No pulse on ports 1 or 2.
- **Near-expiry read:** port 1 idle for 29 edges, `read_enb_1`=1 on the 30th → no pulse. Idle again → pulse after 30 further edges.
- **Persistent non-empty after flush:** `empty_2` held 0 after a pulse → second pulse exactly 31 edges after the first.
